// File: rtl/pkt_seg_collector_pkg.sv
// Shared definitions for the packet segment collector and the reassembly stage
// that consumes its records: segment geometry, FSM states and seg_vec field offsets.
package pkt_seg_collector_pkg;

    localparam int SEG_WIDTH      = 256;
    localparam int NUM_SEGS       = 4;
    localparam int KEEP_WIDTH     = SEG_WIDTH / 8;
    localparam int KEEP_CNT_WIDTH = $clog2(KEEP_WIDTH + 1);
    localparam int TUSER_WIDTH    = 128;
    localparam int LEN_WIDTH      = 8;
    localparam int SEG_VEC_WIDTH  = NUM_SEGS * SEG_WIDTH;

    // Capture FSM. SKIP swallows the tail of packets longer than NUM_SEGS beats.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SKIP    = 2'd2
    } state_t;

    // Bit offset of captured beat k inside seg_vec.
    function automatic int seg_offset(input int k);
        return k * SEG_WIDTH;
    endfunction

endpackage

// File: rtl/pkt_seg_collector_popcount.sv
// Counts the set bits of one tkeep word. Lanes need not be contiguous.
module keep_popcount #(
    parameter int KEEP_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [CNT_WIDTH-1:0]  count
);

    // Plain ripple sum; the tree shape is left to synthesis.
    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            count = count + CNT_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/pkt_seg_collector.sv
// Passive AXI4-Stream tap: captures the first NUM_SEGS accepted beats of each
// packet, sums their valid bytes, latches the first-beat tuser and emits one
// single-cycle record per packet. It never drives tready.
module pkt_seg_collector
    import pkt_seg_collector_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = SEG_WIDTH,
    parameter int C_S_AXIS_TUSER_WIDTH = TUSER_WIDTH,
    parameter int NUM_SEGS_P           = NUM_SEGS,
    parameter int LEN_WIDTH_P          = LEN_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]           s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]            s_axis_tuser,
    input  logic                                       s_axis_tvalid,
    input  logic                                       s_axis_tready,
    input  logic                                       s_axis_tlast,
    output logic [NUM_SEGS_P*C_S_AXIS_DATA_WIDTH-1:0]  seg_vec,
    output logic [LEN_WIDTH_P-1:0]                     seg_bytes,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]            seg_tuser,
    output logic                                       seg_trunc,
    output logic                                       seg_valid,
    output logic [31:0]                                pkt_cnt
);

    localparam int VEC_W         = NUM_SEGS_P * C_S_AXIS_DATA_WIDTH;
    localparam int KEEP_W        = C_S_AXIS_DATA_WIDTH / 8;
    localparam int CNT_W         = $clog2(KEEP_W + 1);
    localparam int IDX_W         = $clog2(NUM_SEGS_P);
    localparam int SEG_SHIFT     = $clog2(C_S_AXIS_DATA_WIDTH);
    localparam int OFS_W         = IDX_W + SEG_SHIFT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEGS_P - 1);

    state_t                          state, state_next;
    logic [IDX_W-1:0]                seg_idx, seg_idx_next;
    logic [VEC_W-1:0]                work_vec, work_vec_next;
    logic [LEN_WIDTH_P-1:0]          work_bytes, work_bytes_next;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] work_tuser, work_tuser_next;
    logic [CNT_W-1:0]                keep_cnt;
    logic [OFS_W-1:0]                wr_offset;
    logic                            acc;
    logic                            emit;
    logic                            emit_trunc;

    assign acc       = s_axis_tvalid & s_axis_tready;
    assign wr_offset = {seg_idx, {SEG_SHIFT{1'b0}}};

    keep_popcount #(
        .KEEP_WIDTH (KEEP_W),
        .CNT_WIDTH  (CNT_W)
    ) u_keep_popcount (
        .keep  (s_axis_tkeep),
        .count (keep_cnt)
    );

    // Next-state, working-register updates and emit decision for each accepted beat.
    always_comb begin
        state_next      = state;
        seg_idx_next    = seg_idx;
        work_vec_next   = work_vec;
        work_bytes_next = work_bytes;
        work_tuser_next = work_tuser;
        emit            = 1'b0;
        emit_trunc      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (acc) begin
                    work_vec_next                          = '0;
                    work_vec_next[C_S_AXIS_DATA_WIDTH-1:0] = s_axis_tdata;
                    work_bytes_next                        = LEN_WIDTH_P'(keep_cnt);
                    work_tuser_next                        = s_axis_tuser;
                    if (s_axis_tlast) begin
                        emit = 1'b1;
                    end else begin
                        state_next   = ST_COLLECT;
                        seg_idx_next = IDX_W'(1);
                    end
                end
            end
            ST_COLLECT: begin
                if (acc) begin
                    work_vec_next[wr_offset +: C_S_AXIS_DATA_WIDTH] = s_axis_tdata;
                    work_bytes_next = work_bytes + LEN_WIDTH_P'(keep_cnt);
                    if (s_axis_tlast) begin
                        emit         = 1'b1;
                        state_next   = ST_IDLE;
                        seg_idx_next = '0;
                    end else if (seg_idx == LAST_IDX) begin
                        emit         = 1'b1;
                        emit_trunc   = 1'b1;
                        state_next   = ST_SKIP;
                        seg_idx_next = '0;
                    end else begin
                        seg_idx_next = seg_idx + 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                if (acc && s_axis_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                seg_idx_next = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Working registers; a reset discards any partial capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_idx    <= '0;
            work_vec   <= '0;
            work_bytes <= '0;
            work_tuser <= '0;
        end else begin
            seg_idx    <= seg_idx_next;
            work_vec   <= work_vec_next;
            work_bytes <= work_bytes_next;
            work_tuser <= work_tuser_next;
        end
    end

    // Output record loads from the post-beat working values so the record appears one cycle after its beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_vec   <= '0;
            seg_bytes <= '0;
            seg_tuser <= '0;
            seg_trunc <= 1'b0;
            seg_valid <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            seg_valid <= emit;
            if (emit) begin
                seg_vec   <= work_vec_next;
                seg_bytes <= work_bytes_next;
                seg_tuser <= work_tuser_next;
                seg_trunc <= emit_trunc;
                pkt_cnt   <= pkt_cnt + 32'd1;
            end
        end
    end

endmodule
